// File: rtl/sr_checker.sv
// SR latch checker: tracks expected Q from observed S/R, waits SETTLE cycles after a change, then compares Q/Qn.
// Optional macro SR_CHECK_SYNC_EN adds two-flop input synchronizers (+2 cycles latency); no backpressure, outputs registered.
module sr_checker #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic       r,
  input  logic       q,
  input  logic       qn,
  input  logic       clr,
  output logic       exp_q,
  output logic       exp_valid,
  output logic [1:0] state,
  output logic       err_pulse,
  output logic       err_flag,
  output logic [7:0] err_cnt,
  output logic [7:0] forbid_cnt
);

  typedef enum logic [1:0] {
    ST_UNKNOWN  = 2'b00,
    ST_SETTLING = 2'b01,
    ST_CHECK    = 2'b10,
    ST_FORBID   = 2'b11
  } state_e;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  logic s_w, r_w, q_w, qn_w;

`ifdef SR_CHECK_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {s, r, q, qn};
      sync2_q <= sync1_q;
    end
  end

  assign {s_w, r_w, q_w, qn_w} = sync2_q;
`else
  assign {s_w, r_w, q_w, qn_w} = {s, r, q, qn};
`endif

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] hist_q;
  logic       exp_q_q, exp_q_d;
  logic       exp_vld_q, exp_vld_d;
  logic       err_pulse_q, err_pulse_d;
  logic       err_flag_q, err_flag_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] forbid_cnt_q, forbid_cnt_d;

  logic [1:0] sr;
  logic       change;

  assign sr     = {s_w, r_w};
  assign change = (sr != hist_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exp_q_d      = exp_q_q;
    exp_vld_d    = exp_vld_q;
    err_flag_d   = err_flag_q;
    err_cnt_d    = err_cnt_q;
    forbid_cnt_d = forbid_cnt_q;

    case (sr)
      2'b10:   begin exp_q_d = 1'b1; exp_vld_d = 1'b1; end
      2'b01:   begin exp_q_d = 1'b0; exp_vld_d = 1'b1; end
      2'b11:   exp_vld_d = 1'b0;
      default: ;
    endcase

    if (change) begin
      if (sr == 2'b11) begin
        state_d = ST_FORBID;
        cnt_d   = 4'd0;
        if (forbid_cnt_q != 8'hFF) forbid_cnt_d = forbid_cnt_q + 8'd1;
      end else if (sr == 2'b00 && (hist_q == 2'b11 || state_q == ST_UNKNOWN)) begin
        // Releasing both inputs together races inside the latch: outcome unknown.
        state_d = ST_UNKNOWN;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_SETTLING;
        cnt_d   = SETTLE_L;
      end
    end else if (state_q == ST_SETTLING) begin
      if (cnt_q <= 4'd1) begin
        state_d = ST_CHECK;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    // Skip the compare on a change edge: the latch has not had time to respond yet.
    err_pulse_d = (state_q == ST_CHECK) && exp_vld_q && !change &&
                  ((q_w != exp_q_q) || (qn_w == q_w));

    if (err_pulse_d) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    if (clr) begin
      err_flag_d   = 1'b0;
      err_cnt_d    = 8'd0;
      forbid_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNKNOWN;
      cnt_q        <= 4'd0;
      hist_q       <= 2'b00;
      exp_q_q      <= 1'b0;
      exp_vld_q    <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= 8'd0;
      forbid_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hist_q       <= sr;
      exp_q_q      <= exp_q_d;
      exp_vld_q    <= exp_vld_d;
      err_pulse_q  <= err_pulse_d;
      err_flag_q   <= err_flag_d;
      err_cnt_q    <= err_cnt_d;
      forbid_cnt_q <= forbid_cnt_d;
    end
  end

  assign state      = state_q;
  assign exp_q      = exp_q_q;
  assign exp_valid  = exp_vld_q;
  assign err_pulse  = err_pulse_q;
  assign err_flag   = err_flag_q;
  assign err_cnt    = err_cnt_q;
  assign forbid_cnt = forbid_cnt_q;

endmodule

// File: tb/tb_sr_checker.sv
// Directed bench for sr_checker with SETTLE=4 and synchronizers disabled.
module tb_sr_checker;

  logic       clk = 1'b0;
  logic       rst_n, s, r, q, qn, clr;
  logic       exp_q, exp_valid, err_pulse, err_flag;
  logic [1:0] state;
  logic [7:0] err_cnt, forbid_cnt;

  int checks   = 0;
  int failures = 0;

  sr_checker #(.SETTLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s),
    .r          (r),
    .q          (q),
    .qn         (qn),
    .clr        (clr),
    .exp_q      (exp_q),
    .exp_valid  (exp_valid),
    .state      (state),
    .err_pulse  (err_pulse),
    .err_flag   (err_flag),
    .err_cnt    (err_cnt),
    .forbid_cnt (forbid_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},  {6'd0, state},      8'd0);
    check({tag, "_expq"},   {7'd0, exp_q},      8'd0);
    check({tag, "_expv"},   {7'd0, exp_valid},  8'd0);
    check({tag, "_pulse"},  {7'd0, err_pulse},  8'd0);
    check({tag, "_flag"},   {7'd0, err_flag},   8'd0);
    check({tag, "_errcnt"}, err_cnt,            8'd0);
    check({tag, "_fcnt"},   forbid_cnt,         8'd0);
  endtask

  initial begin
    rst_n = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0; qn = 1'b1; clr = 1'b0;
    tick(2);
    check_reset("por");
    rst_n = 1'b1;
    tick(1);
    check("idle_state", {6'd0, state}, 8'd0);

    // Set: four SETTLING cycles then CHECK
    s = 1'b1; r = 1'b0; q = 1'b1; qn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("set_settling", {6'd0, state}, 8'd1);
    end
    check("set_expq", {7'd0, exp_q}, 8'd1);
    check("set_expv", {7'd0, exp_valid}, 8'd1);
    tick(1);
    check("set_check", {6'd0, state}, 8'd2);
    tick(2);
    check("set_pulse", {7'd0, err_pulse}, 8'd0);
    check("set_errcnt", err_cnt, 8'd0);

    // Hold 00, then reset with 01
    s = 1'b0; r = 1'b0;
    tick(1);
    check("hold_settling", {6'd0, state}, 8'd1);
    check("hold_expq", {7'd0, exp_q}, 8'd1);
    tick(4);
    check("hold_check", {6'd0, state}, 8'd2);
    tick(2);
    check("hold_errcnt", err_cnt, 8'd0);
    check("hold_expq2", {7'd0, exp_q}, 8'd1);
    s = 1'b0; r = 1'b1; q = 1'b0; qn = 1'b1;
    tick(1);
    check("rst_settling", {6'd0, state}, 8'd1);
    check("rst_expq", {7'd0, exp_q}, 8'd0);
    tick(4);
    check("rst_check", {6'd0, state}, 8'd2);
    tick(2);
    check("rst_pulse", {7'd0, err_pulse}, 8'd0);
    check("rst_errcnt", err_cnt, 8'd0);

    // Q stuck high while reset held
    q = 1'b1; qn = 1'b0;
    tick(1);
    check("stuck_pulse", {7'd0, err_pulse}, 8'd1);
    check("stuck_flag", {7'd0, err_flag}, 8'd1);
    check("stuck_cnt1", err_cnt, 8'd1);
    tick(4);
    check("stuck_cnt5", err_cnt, 8'd5);
    clr = 1'b1;
    tick(1);
    check("clr_errcnt", err_cnt, 8'd0);
    check("clr_flag", {7'd0, err_flag}, 8'd0);
    check("clr_pulse_kept", {7'd0, err_pulse}, 8'd1);
    clr = 1'b0;
    tick(254);
    check("sat_254", err_cnt, 8'd254);
    tick(1);
    check("sat_255", err_cnt, 8'd255);
    tick(3);
    check("sat_hold", err_cnt, 8'd255);
    check("sat_flag", {7'd0, err_flag}, 8'd1);
    q = 1'b0; qn = 1'b1;
    tick(1);
    check("good_q_pulse", {7'd0, err_pulse}, 8'd0);
    check("good_q_cnt", err_cnt, 8'd255);
    q = 1'b0; qn = 1'b0;
    tick(1);
    check("bad_qn_pulse", {7'd0, err_pulse}, 8'd1);

    // Forbidden 11, then race release to 00
    q = 1'b0; qn = 1'b1; clr = 1'b1;
    tick(1);
    check("clr2_errcnt", err_cnt, 8'd0);
    check("clr2_fcnt", forbid_cnt, 8'd0);
    clr = 1'b0;
    s = 1'b1; r = 1'b1; q = 1'b1; qn = 1'b1;
    tick(1);
    check("forbid_state", {6'd0, state}, 8'd3);
    check("forbid_cnt1", forbid_cnt, 8'd1);
    check("forbid_expv", {7'd0, exp_valid}, 8'd0);
    tick(3);
    check("forbid_hold", {6'd0, state}, 8'd3);
    check("forbid_once", forbid_cnt, 8'd1);
    check("forbid_pulse", {7'd0, err_pulse}, 8'd0);
    s = 1'b0; r = 1'b0; q = 1'b0; qn = 1'b0;
    tick(1);
    check("unk_state", {6'd0, state}, 8'd0);
    check("unk_expv", {7'd0, exp_valid}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      q = ~q;
      tick(1);
      check("unk_stay", {6'd0, state}, 8'd0);
      check("unk_pulse", {7'd0, err_pulse}, 8'd0);
    end
    check("unk_errcnt", err_cnt, 8'd0);
    check("unk_fcnt", forbid_cnt, 8'd1);

    // Rapid toggling never settles
    q = 1'b1; qn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s = (i % 2 == 0);
      r = ~s;
      tick(1);
      check("toggle_a", {6'd0, state}, 8'd1);
      tick(1);
      check("toggle_b", {6'd0, state}, 8'd1);
    end
    check("toggle_errcnt", err_cnt, 8'd0);
    tick(3);
    check("toggle_check", {6'd0, state}, 8'd2);
    check("toggle_errcnt2", err_cnt, 8'd0);
    tick(3);
    check("toggle_err3", err_cnt, 8'd3);
    check("toggle_flag", {7'd0, err_flag}, 8'd1);

    // Reset mid-SETTLING
    s = 1'b1; r = 1'b0;
    tick(1);
    check("pre_rst_state", {6'd0, state}, 8'd1);
    check("pre_rst_pulse", {7'd0, err_pulse}, 8'd0);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    tick(2);
    check_reset("held_rst");
    rst_n = 1'b1;
    tick(1);
    check("post_rst_state", {6'd0, state}, 8'd1);
    check("post_rst_expq", {7'd0, exp_q}, 8'd1);
    check("post_rst_errcnt", err_cnt, 8'd0);
    tick(4);
    check("post_rst_check", {6'd0, state}, 8'd2);
    check("post_rst_pulse", {7'd0, err_pulse}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
